// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage PCPU.
// Detects load-use hazards and branch/jalr operand hazards that forwarding
// cannot cover. Holds PC and IF/ID, inserts bubbles into ID/EX, and squashes
// wrong-path fetches. Multi-cycle stalls run in a small FSM with a down-counter.
//
// state | meaning
// RUN   | normal flow; hazard detection active, 0/1-cycle stalls handled here
// STALL | remaining cycles of a multi-cycle stall; hazard inputs ignored
module hazard_stall_ctrl #(
  parameter logic [2:0] NPC_BRANCH = 3'b001,
  parameter logic [2:0] NPC_JALR   = 3'b100,
  parameter int         CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ext_hold,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [2:0]       NPCOp,
  input  logic             ID_branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_MemRead,
  output logic             PC_write_en,
  output logic             IF_ID_write_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             stall_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, STALL} state_e;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic       br;
  logic       m_idex;
  logic       m_exmem;
  logic [1:0] need_n;
  logic       stall;

  // Register r (nonzero) is actually read by the ID instruction.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic use1,
                                     input logic use2);
    return (r != 5'd0) && (((r == rs1) && use1) || ((r == rs2) && use2));
  endfunction

  // Required stall length for the instruction in ID; largest requirement wins.
  always_comb begin
    br      = (NPCOp == NPC_BRANCH) || (NPCOp == NPC_JALR);
    m_idex  = reg_match(ID_EX_rd, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2);
    m_exmem = reg_match(EX_MEM_rd, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2);
    need_n  = 2'd0;
    if (br && m_idex && ID_EX_MemRead) begin
      need_n = 2'd2;
    end else if ((br && m_idex && ID_EX_RegWrite) ||
                 (br && m_exmem && EX_MEM_MemRead) ||
                 (!br && m_idex && ID_EX_MemRead)) begin
      need_n = 2'd1;
    end
    stall = (state_q == STALL) || (need_n != 2'd0);
  end

  // Stall FSM, remaining-cycle counter and saturating stall statistic; all frozen on ext_hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= RUN;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
    end else if (!ext_hold) begin
      case (state_q)
        RUN: begin
          if (need_n >= 2'd2) begin
            state_q <= STALL;
            cnt_q   <= need_n - 2'd1;
          end
        end
        STALL: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      if (stall && !(&stall_cycles_q)) begin
        stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs react in the detect cycle; forced low while reset is asserted.
  always_comb begin
    PC_write_en    = rstn && !stall && !ext_hold;
    IF_ID_write_en = rstn && !stall && !ext_hold;
    ID_EX_flush    = rstn && stall && !ext_hold;
    IF_ID_flush    = rstn && ID_branch_taken && !stall && !ext_hold;
    stall_state    = rstn && (state_q == STALL);
    stall_cycles   = stall_cycles_q;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random stimulus against a remaining-cycles model.
module tb_hazard_stall_ctrl;
  localparam int CW = 6;
  localparam longint SAT = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ext_hold, use1, use2, taken, exrw, exmr, memmr;
  logic [4:0] rs1, rs2, exrd, memrd;
  logic [2:0] npc;
  logic pcwe, ifwe, iffl, exfl, st;
  logic [CW-1:0] sc;

  int checks = 0;
  int failures = 0;

  hazard_stall_ctrl #(.NPC_BRANCH(3'b001), .NPC_JALR(3'b100), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .ext_hold(ext_hold),
    .ID_rs1(rs1), .ID_rs2(rs2), .ID_use_rs1(use1), .ID_use_rs2(use2),
    .NPCOp(npc), .ID_branch_taken(taken),
    .ID_EX_rd(exrd), .ID_EX_RegWrite(exrw), .ID_EX_MemRead(exmr),
    .EX_MEM_rd(memrd), .EX_MEM_MemRead(memmr),
    .PC_write_en(pcwe), .IF_ID_write_en(ifwe), .IF_ID_flush(iffl),
    .ID_EX_flush(exfl), .stall_state(st), .stall_cycles(sc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic benign();
    ext_hold = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0; npc = 0; taken = 0;
    exrd = 0; exrw = 0; exmr = 0; memrd = 0; memmr = 0;
  endtask

  // ---------------- reference model ----------------
  int     m_rem;   // stall cycles still owed after the current one
  longint m_cnt;

  function automatic bit uses(input logic [4:0] r);
    return r != 0 && ((r == rs1 && use1) || (r == rs2 && use2));
  endfunction

  function automatic int req_n();
    bit b = (npc == 3'b001) || (npc == 3'b100);
    int n = 0;
    if (b && uses(exrd) && exmr) n = 2;
    if (n < 1 && b && uses(exrd) && exrw && !exmr) n = 1;
    if (n < 1 && b && uses(memrd) && memmr) n = 1;
    if (n < 1 && !b && uses(exrd) && exmr) n = 1;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    benign();
    @(negedge clk);
    rstn = 1;
    m_rem = 0;
    m_cnt = 0;
  endtask

  // Compare all outputs against the model, then let one clock edge pass.
  task automatic model_cycle(input string tag);
    int n;
    bit s;
    #1;
    n = (m_rem > 0) ? 0 : req_n();
    s = (m_rem > 0) || (n > 0);
    chk({tag, " PC_write_en"}, pcwe, !s && !ext_hold);
    chk({tag, " IF_ID_write_en"}, ifwe, !s && !ext_hold);
    chk({tag, " ID_EX_flush"}, exfl, s && !ext_hold);
    chk({tag, " IF_ID_flush"}, iffl, taken && !s && !ext_hold);
    chk({tag, " stall_state"}, st, m_rem > 0);
    chk({tag, " stall_cycles"}, sc, m_cnt);
    @(posedge clk);
    if (!ext_hold) begin
      if (s && m_cnt < SAT) m_cnt++;
      if (m_rem > 0) m_rem--;
      else if (n >= 2) m_rem = n - 1;
    end
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       use1, use2;
    logic [2:0] npc;
    logic       taken;
    logic [4:0] exrd;
    logic       exrw, exmr;
    logic [4:0] memrd;
    logic       memmr, hold;
    logic       e_pcwe, e_exfl, e_iffl, e_st_next;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [4:0] a1, logic [4:0] a2, logic u1, logic u2,
                              logic [2:0] op, logic tk, logic [4:0] xr, logic xw,
                              logic xm, logic [4:0] mr, logic mm, logic hd,
                              logic p, logic f, logic i, logic s);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.use1 = u1; v.use2 = u2; v.npc = op; v.taken = tk;
    v.exrd = xr; v.exrw = xw; v.exmr = xm; v.memrd = mr; v.memmr = mm; v.hold = hd;
    v.e_pcwe = p; v.e_exfl = f; v.e_iffl = i; v.e_st_next = s;
    return v;
  endfunction

  initial begin
    benign();
    m_rem = 0;
    m_cnt = 0;
    // reset state
    #2;
    chk("reset PC_write_en", pcwe, 0);
    chk("reset ID_EX_flush", exfl, 0);
    chk("reset stall_cycles", sc, 0);
    do_reset();

    //              rs1 rs2 u1 u2 npc   tk exrd rw mr memrd mm hd  pcwe exfl iffl st
    vecs.push_back(mk(5, 0, 1, 1, 3'd0, 0, 5,  1, 1, 0,  0, 0,  0, 1, 0, 0)); // load-use
    vecs.push_back(mk(5, 0, 1, 1, 3'd1, 0, 5,  1, 1, 5,  1, 0,  0, 1, 0, 1)); // beq after lw
    vecs.push_back(mk(6, 0, 1, 0, 3'd4, 1, 6,  1, 0, 0,  0, 0,  0, 1, 0, 0)); // jalr after addi
    vecs.push_back(mk(0, 0, 1, 0, 3'd0, 0, 0,  1, 1, 0,  0, 0,  1, 0, 0, 0)); // x0 never hazards
    vecs.push_back(mk(7, 0, 0, 0, 3'd0, 0, 7,  1, 1, 0,  0, 0,  1, 0, 0, 0)); // rs1 not used
    vecs.push_back(mk(1, 9, 0, 1, 3'd1, 0, 3,  1, 1, 9,  1, 0,  0, 1, 0, 0)); // branch, EX_MEM load
    vecs.push_back(mk(1, 9, 0, 1, 3'd1, 1, 3,  1, 1, 9,  0, 0,  1, 0, 1, 0)); // EX_MEM non-load
    vecs.push_back(mk(4, 0, 1, 0, 3'd0, 0, 4,  1, 0, 0,  0, 0,  1, 0, 0, 0)); // ALU fwd covers
    vecs.push_back(mk(5, 0, 1, 0, 3'd0, 1, 5,  1, 1, 0,  0, 1,  0, 0, 0, 0)); // held
    vecs.push_back(mk(2, 8, 0, 1, 3'd2, 0, 8,  1, 1, 0,  0, 0,  0, 1, 0, 0)); // jal: plain load-use
    vecs.push_back(mk(3, 0, 1, 0, 3'd4, 0, 3,  0, 1, 0,  0, 0,  0, 1, 0, 1)); // jalr after lw

    foreach (vecs[k]) begin
      rs1 = vecs[k].rs1; rs2 = vecs[k].rs2; use1 = vecs[k].use1; use2 = vecs[k].use2;
      npc = vecs[k].npc; taken = vecs[k].taken; exrd = vecs[k].exrd;
      exrw = vecs[k].exrw; exmr = vecs[k].exmr; memrd = vecs[k].memrd;
      memmr = vecs[k].memmr; ext_hold = vecs[k].hold;
      #1;
      chk($sformatf("vec%0d PC_write_en", k), pcwe, vecs[k].e_pcwe);
      chk($sformatf("vec%0d IF_ID_write_en", k), ifwe, vecs[k].e_pcwe);
      chk($sformatf("vec%0d ID_EX_flush", k), exfl, vecs[k].e_exfl);
      chk($sformatf("vec%0d IF_ID_flush", k), iffl, vecs[k].e_iffl);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d stall_state next", k), st, vecs[k].e_st_next);
      benign();
      repeat (2) @(negedge clk);
    end

    // beq x5,x0 behind lw x5: two stall cycles, second one in STALL
    do_reset();
    npc = 3'b001; rs1 = 5; use1 = 1; use2 = 1; exrd = 5; exrw = 1; exmr = 1;
    memrd = 5; memmr = 1;
    #1;
    chk("seq2 c1 PC_write_en", pcwe, 0);
    chk("seq2 c1 ID_EX_flush", exfl, 1);
    chk("seq2 c1 stall_state", st, 0);
    @(negedge clk);
    #1;
    chk("seq2 c2 stall_state", st, 1);
    chk("seq2 c2 PC_write_en", pcwe, 0);
    chk("seq2 c2 stall_cycles", sc, 1);
    @(negedge clk);
    benign();
    #1;
    chk("seq2 c3 stall_state", st, 0);
    chk("seq2 c3 PC_write_en", pcwe, 1);
    chk("seq2 c3 stall_cycles", sc, 2);

    // jalr via x6 behind addi x6: one stall, then redirect flush
    do_reset();
    npc = 3'b100; rs1 = 6; use1 = 1; exrd = 6; exrw = 1; taken = 1;
    #1;
    chk("seq3 c1 PC_write_en", pcwe, 0);
    chk("seq3 c1 IF_ID_flush", iffl, 0);
    chk("seq3 c1 ID_EX_flush", exfl, 1);
    @(negedge clk);
    exrd = 0; exrw = 0;
    #1;
    chk("seq3 c2 IF_ID_flush", iffl, 1);
    chk("seq3 c2 PC_write_en", pcwe, 1);
    chk("seq3 c2 ID_EX_flush", exfl, 0);
    @(negedge clk);
    benign();
    #1;
    chk("seq3 c3 IF_ID_flush", iffl, 0);

    // ext_hold during the STALL cycle of a 2-cycle stall
    do_reset();
    npc = 3'b001; rs1 = 5; use1 = 1; exrd = 5; exmr = 1; exrw = 1;
    #1;
    chk("seq5 c1 ID_EX_flush", exfl, 1);
    @(negedge clk);
    ext_hold = 1;
    #1;
    chk("seq5 hold stall_state", st, 1);
    chk("seq5 hold PC_write_en", pcwe, 0);
    chk("seq5 hold ID_EX_flush", exfl, 0);
    chk("seq5 hold stall_cycles", sc, 1);
    @(negedge clk);
    #1;
    chk("seq5 hold2 stall_state", st, 1);
    chk("seq5 hold2 stall_cycles", sc, 1);
    @(negedge clk);
    ext_hold = 0;
    #1;
    chk("seq5 rel stall_state", st, 1);
    chk("seq5 rel ID_EX_flush", exfl, 1);
    @(negedge clk);
    benign();
    #1;
    chk("seq5 after stall_state", st, 0);
    chk("seq5 after PC_write_en", pcwe, 1);
    chk("seq5 after stall_cycles", sc, 2);

    // async reset in the middle of a STALL
    do_reset();
    npc = 3'b001; rs1 = 5; use1 = 1; exrd = 5; exmr = 1;
    @(posedge clk);
    #2;
    chk("seq6 pre stall_state", st, 1);
    rstn = 0;
    #1;
    chk("seq6 rst stall_state", st, 0);
    chk("seq6 rst ID_EX_flush", exfl, 0);
    chk("seq6 rst PC_write_en", pcwe, 0);
    chk("seq6 rst stall_cycles", sc, 0);
    @(negedge clk);
    rstn = 1;
    npc = 3'b000;  // plain load-use: one cycle, evaluated as RUN
    #1;
    chk("seq6 rel stall_state", st, 0);
    chk("seq6 rel ID_EX_flush", exfl, 1);
    @(posedge clk);
    #1;
    chk("seq6 rel next stall_state", st, 0);

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ops[4];
      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b010;
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom);
      npc = ops[$urandom_range(0, 3)];
      taken = 1'($urandom);
      exrd = 5'($urandom_range(0, 3)); exrw = 1'($urandom); exmr = 1'($urandom);
      memrd = 5'($urandom_range(0, 3)); memmr = 1'($urandom);
      ext_hold = ($urandom_range(0, 4) == 0);
      model_cycle($sformatf("rnd%0d", i));
    end
    chk("rnd saturation reached", sc, SAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
